s2abus: RTL

S2ABUS -- requirements
Module: s2abus

---
 rtl/dflow_pkg.sv | 15 +
 rtl/sbus_fifo.sv | 54 +++++
 rtl/s2abus.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dflow_pkg.sv
// Shared definitions for the simple-bus to AXI-Stream dataflow blocks:
// control-byte codes and the input FSM state enumeration.
package dflow_pkg;

  localparam logic [7:0] SBUS_CTL_FIRST = 8'hFF;
  localparam logic [7:0] SBUS_CTL_LAST  = 8'h01;
  localparam logic [7:0] SBUS_CTL_IDLE  = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } sbus_state_e;

endpackage

// File: rtl/sbus_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count and a
// tail-overwrite port used to truncate a packet in place when full.
module sbus_fifo #(
  parameter int WIDTH = 289,
  parameter int DEPTH = 64
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     wr_en,
  input  logic                     ovr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count
);
  import dflow_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    tail_ptr;

  assign tail_ptr = wr_ptr - AW'(1);
  assign rd_data  = mem[rd_ptr];
  assign rd_valid = (count != '0);

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end else if (ovr_en) begin
      mem[tail_ptr] <= wr_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/s2abus.sv
// Simple-bus (byte 0 in MSBs, no backpressure) to AXI-Stream bridge with
// packet-level admission control. Optional drop counters: S2ABUS_DROP_CNT_EN.
module s2abus #(
  parameter int TDATA_WIDTH   = 256,
  parameter int FIFO_DEPTH    = 64,
  parameter int MAX_PKT_BEATS = 32
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     S_SBUS_VALID,
  input  logic [TDATA_WIDTH-1:0]   S_SBUS_TDATA,
  input  logic [TDATA_WIDTH/8-1:0] S_SBUS_TKEEP,
  input  logic [7:0]               S_SBUS_CTL,
  output logic                     M_AXIS_TVALID,
  output logic [TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                     M_AXIS_TLAST,
  input  logic                     M_AXIS_TREADY
`ifdef S2ABUS_DROP_CNT_EN
  ,
  output logic [31:0]              DROP_PKT_CNT,
  output logic [31:0]              DROP_BEAT_CNT
`endif
);
  import dflow_pkg::*;

  localparam int KW = TDATA_WIDTH / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + KW + TDATA_WIDTH;

  function automatic logic [TDATA_WIDTH-1:0] rev_bytes(input logic [TDATA_WIDTH-1:0] d);
    logic [TDATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < KW; i++) r[8*i +: 8] = d[TDATA_WIDTH-8-8*i +: 8];
    return r;
  endfunction

  function automatic logic [KW-1:0] rev_bits(input logic [KW-1:0] k);
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i < KW; i++) r[i] = k[KW-1-i];
    return r;
  endfunction

  sbus_state_e      state, state_nxt;
  logic [AW:0]      count;
  logic [AW:0]      free;
  logic             full;
  logic             beat, is_last, admit;
  logic             wr_en, ovr_en, pop;
  logic [EW-1:0]    wr_data, rd_data;
  logic             rd_valid;

  assign beat    = S_SBUS_VALID && (S_SBUS_CTL != SBUS_CTL_IDLE);
  assign is_last = (S_SBUS_CTL == SBUS_CTL_LAST);
  assign free    = (AW+1)'(FIFO_DEPTH) - count;
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  // Admission looks only at the occupancy at cycle start; a same-cycle pop does not help.
  assign admit   = is_last ? (free != '0) : (free >= (AW+1)'(MAX_PKT_BEATS));

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    ovr_en    = 1'b0;
    if (beat) begin
      case (state)
        ST_IDLE: begin
          if (admit) begin
            wr_en = 1'b1;
            if (!is_last) state_nxt = ST_PASS;
          end else if (!is_last) begin
            state_nxt = ST_DROP;
          end
        end
        ST_PASS: begin
          if (full) begin
            ovr_en    = 1'b1;
            state_nxt = is_last ? ST_IDLE : ST_DROP;
          end else begin
            wr_en = 1'b1;
            if (is_last) state_nxt = ST_IDLE;
          end
        end
        ST_DROP: begin
          if (is_last) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // A truncating overwrite always closes the stored packet.
  assign wr_data = {is_last | ovr_en, rev_bits(S_SBUS_TKEEP), rev_bytes(S_SBUS_TDATA)};
  assign pop     = rd_valid && M_AXIS_TREADY;

  sbus_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk     (ACLK),
    .aresetn  (ARESETN),
    .wr_en    (wr_en),
    .ovr_en   (ovr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count)
  );

  assign M_AXIS_TVALID = rd_valid;
  assign M_AXIS_TLAST  = rd_valid & rd_data[EW-1];
  assign M_AXIS_TKEEP  = rd_valid ? rd_data[EW-2 -: KW] : '0;
  assign M_AXIS_TDATA  = rd_valid ? rd_data[TDATA_WIDTH-1:0] : '0;

`ifdef S2ABUS_DROP_CNT_EN
  logic drop_pkt, drop_beat;

  // Every valid non-idle beat that is not appended counts as discarded, including the truncating one.
  assign drop_beat = beat && !wr_en;
  assign drop_pkt  = beat && (ovr_en || ((state == ST_IDLE) && !wr_en));

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      DROP_PKT_CNT  <= '0;
      DROP_BEAT_CNT <= '0;
    end else begin
      if (drop_pkt && (DROP_PKT_CNT != 32'hFFFF_FFFF))   DROP_PKT_CNT  <= DROP_PKT_CNT + 32'd1;
      if (drop_beat && (DROP_BEAT_CNT != 32'hFFFF_FFFF)) DROP_BEAT_CNT <= DROP_BEAT_CNT + 32'd1;
    end
  end
`endif

endmodule
